// File: rtl/video_ram_pkg.sv
// Shared types and constants for the video RAM
// and its fill/copy engine.
package video_ram_pkg;

    localparam int AW_DEF = 15;
    localparam int DW_DEF = 8;

    localparam logic MODE_FILL = 1'b0;
    localparam logic MODE_COPY = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RD,
        WR
    } state_t;

endpackage

// File: rtl/video_ram_dp.sv
// True dual-port read-first block RAM.
// Port A read/write, port B read-only.
module video_ram_dp #(
  parameter int AW        = 15,
  parameter int DW        = 8,
  parameter     INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] a_addr,
  input  logic          a_we,
  input  logic [DW-1:0] a_din,
  output logic [DW-1:0] a_dout,
  input  logic [AW-1:0] b_addr,
  output logic [DW-1:0] b_dout
);

  (* ram_style = "block" *)
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_dout <= '0;
      b_dout <= '0;
    end else begin
      a_dout <= mem[a_addr];
      b_dout <= mem[b_addr];
    end
  end

endmodule

// File: rtl/video_ram_blit.sv
// Video RAM with fill/copy engine on port A;
// the CPU always wins port A, video owns port B.
module video_ram_blit
    import video_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = AW_DEF,
    parameter int DATA_WIDTH = DW_DEF,
    parameter     INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  cpu_we,
    input  logic                  cpu_re,
    input  logic [DATA_WIDTH-1:0] cpu_din,
    output logic [DATA_WIDTH-1:0] cpu_dout,
    output logic                  cpu_dout_vld,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic [DATA_WIDTH-1:0] vid_dout,
    input  logic                  cmd_start,
    input  logic                  cmd_mode,
    input  logic                  cmd_desc,
    input  logic [ADDR_WIDTH-1:0] cmd_src,
    input  logic [ADDR_WIDTH-1:0] cmd_dst,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    input  logic [DATA_WIDTH-1:0] cmd_val,
    input  logic                  cmd_abort,
    output logic                  busy,
    output logic                  done
);

    localparam int AW = ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;

    state_t        state;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW:0]   len;
    logic [DW-1:0] val;
    logic [DW-1:0] hold;
    logic          desc;
    logic          first_wr;

    logic [AW-1:0] a_addr;
    logic          a_we;
    logic [DW-1:0] a_din;
    logic [DW-1:0] a_dout;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] nxt_src;
    logic [AW-1:0] nxt_dst;
    logic          eng_go;
    logic          last;

    assign eng_go  = ~(cpu_we | cpu_re) & ~cmd_abort;
    assign last    = (len == (AW+1)'(1));
    assign nxt_src = desc ? src - 1'b1 : src + 1'b1;
    assign nxt_dst = desc ? dst - 1'b1 : dst + 1'b1;
    // Hold is not loaded yet in the first WR cycle
    assign wr_data = first_wr ? a_dout : hold;
    assign cpu_dout = a_dout;

    always_comb begin
        a_addr = cpu_addr;
        a_we   = cpu_we;
        a_din  = cpu_din;
        if (eng_go) begin
            unique case (state)
                IDLE: ;
                FILL: begin
                    a_addr = dst;
                    a_we   = 1'b1;
                    a_din  = val;
                end
                RD: a_addr = src;
                WR: begin
                    a_addr = dst;
                    a_we   = 1'b1;
                    a_din  = wr_data;
                end
            endcase
        end
    end

    video_ram_dp #(
        .AW       (AW),
        .DW       (DW),
        .INIT_FILE(INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .a_addr(a_addr),
        .a_we  (a_we),
        .a_din (a_din),
        .a_dout(a_dout),
        .b_addr(vid_addr),
        .b_dout(vid_dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            src          <= '0;
            dst          <= '0;
            len          <= '0;
            val          <= '0;
            hold         <= '0;
            desc         <= 1'b0;
            first_wr     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cpu_dout_vld <= 1'b0;
        end else begin
            cpu_dout_vld <= cpu_re & ~cpu_we;
            done         <= 1'b0;
            if (cmd_abort) begin
                state    <= IDLE;
                busy     <= 1'b0;
                first_wr <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: if (cmd_start) begin
                        src  <= cmd_src;
                        dst  <= cmd_dst;
                        len  <= cmd_len;
                        val  <= cmd_val;
                        desc <= cmd_desc;
                        if (cmd_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            busy  <= 1'b1;
                            state <= (cmd_mode == MODE_COPY)
                                     ? RD : FILL;
                        end
                    end
                    FILL: if (eng_go) begin
                        dst <= nxt_dst;
                        len <= len - 1'b1;
                        if (last) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    RD: if (eng_go) begin
                        src      <= nxt_src;
                        state    <= WR;
                        first_wr <= 1'b1;
                    end
                    WR: begin
                        first_wr <= 1'b0;
                        if (first_wr) hold <= a_dout;
                        if (eng_go) begin
                            dst <= nxt_dst;
                            len <= len - 1'b1;
                            if (last) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state <= RD;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_video_ram_blit.sv
// Directed bench for video_ram_blit: fill, copy,
// CPU stealing, wrap, collisions, abort, reset.
module tb_video_ram_blit;

    localparam int AW = 15;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic          cpu_we = 1'b0;
    logic          cpu_re = 1'b0;
    logic [DW-1:0] cpu_din = '0;
    logic [DW-1:0] cpu_dout;
    logic          cpu_dout_vld;
    logic [AW-1:0] vid_addr = '0;
    logic [DW-1:0] vid_dout;
    logic          cmd_start = 1'b0;
    logic          cmd_mode = 1'b0;
    logic          cmd_desc = 1'b0;
    logic [AW-1:0] cmd_src = '0;
    logic [AW-1:0] cmd_dst = '0;
    logic [AW:0]   cmd_len = '0;
    logic [DW-1:0] cmd_val = '0;
    logic          cmd_abort = 1'b0;
    logic          busy;
    logic          done;

    int tests = 0;
    int fails = 0;
    int cyc;

    video_ram_blit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu_addr    (cpu_addr),
        .cpu_we      (cpu_we),
        .cpu_re      (cpu_re),
        .cpu_din     (cpu_din),
        .cpu_dout    (cpu_dout),
        .cpu_dout_vld(cpu_dout_vld),
        .vid_addr    (vid_addr),
        .vid_dout    (vid_dout),
        .cmd_start   (cmd_start),
        .cmd_mode    (cmd_mode),
        .cmd_desc    (cmd_desc),
        .cmd_src     (cmd_src),
        .cmd_dst     (cmd_dst),
        .cmd_len     (cmd_len),
        .cmd_val     (cmd_val),
        .cmd_abort   (cmd_abort),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [AW-1:0] a,
                             input logic [DW-1:0] d);
        cpu_addr = a;
        cpu_din  = d;
        cpu_we   = 1'b1;
        tick();
        cpu_we   = 1'b0;
    endtask

    task automatic cpu_read(input string tag,
                            input logic [AW-1:0] a,
                            input logic [DW-1:0] exp);
        cpu_addr = a;
        cpu_re   = 1'b1;
        tick();
        cpu_re   = 1'b0;
        chk({tag, "_vld"}, 32'(cpu_dout_vld), 32'd1);
        chk(tag, 32'(cpu_dout), 32'(exp));
    endtask

    task automatic start_cmd(input logic mode,
                             input logic desc,
                             input logic [AW-1:0] src,
                             input logic [AW-1:0] dst,
                             input logic [AW:0] len,
                             input logic [DW-1:0] val);
        cmd_mode  = mode;
        cmd_desc  = desc;
        cmd_src   = src;
        cmd_dst   = dst;
        cmd_len   = len;
        cmd_val   = val;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
    endtask

    // Counts busy cycles; optionally pokes a start while busy
    task automatic wait_idle(input bit inject,
                             output int n);
        n = 0;
        while (busy && n < 1000) begin
            if (inject && n == 1) begin
                cmd_mode  = 1'b0;
                cmd_dst   = 15'h0500;
                cmd_len   = 16'd1;
                cmd_val   = 8'hEE;
                cmd_start = 1'b1;
            end
            tick();
            cmd_start = 1'b0;
            n++;
        end
    endtask

    initial begin
        tick();
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_vld", 32'(cpu_dout_vld), 0);
        chk("rst_cpu_dout", 32'(cpu_dout), 0);
        chk("rst_vid_dout", 32'(vid_dout), 0);
        rst_n = 1'b1;
        tick();

        // FILL 16 words of A5 at 0x100
        cpu_write(15'h0110, 8'h3C);
        start_cmd(1'b0, 1'b0, '0, 15'h0100,
                  16'd16, 8'hA5);
        wait_idle(1'b0, cyc);
        chk("fill_cycles", 32'(cyc), 16);
        chk("fill_done", 32'(done), 1);
        tick();
        chk("fill_done_once", 32'(done), 0);
        for (int i = 0; i < 16; i++)
            cpu_read("fill_data", 15'(15'h0100 + i), 8'hA5);
        cpu_read("fill_edge", 15'h0110, 8'h3C);

        // Overlapping descending COPY 0..7 -> 4..11
        for (int i = 0; i < 8; i++)
            cpu_write(15'(i), 8'(i));
        start_cmd(1'b1, 1'b1, 15'd7, 15'd11,
                  16'd8, 8'h00);
        wait_idle(1'b0, cyc);
        chk("copy_cycles", 32'(cyc), 16);
        chk("copy_done", 32'(done), 1);
        for (int i = 0; i < 8; i++)
            cpu_read("copy_data", 15'(4 + i), 8'(i));

        // COPY 32 with CPU reads on every other cycle
        for (int i = 0; i < 32; i++)
            cpu_write(15'(15'h0300 + i), 8'(i ^ 8'h5A));
        start_cmd(1'b1, 1'b0, 15'h0300, 15'h0400,
                  16'd32, 8'h00);
        cyc = 0;
        while (busy && cyc < 1000) begin
            cpu_addr = 15'h0110;
            cpu_re   = (cyc % 2 == 0);
            tick();
            chk("steal_vld", 32'(cpu_dout_vld),
                32'(cyc % 2 == 0));
            if (cyc % 2 == 0)
                chk("steal_data", 32'(cpu_dout), 32'h3C);
            cyc++;
        end
        cpu_re = 1'b0;
        chk("steal_cycles", 32'(cyc), 128);
        chk("steal_done", 32'(done), 1);
        for (int i = 0; i < 32; i++)
            cpu_read("steal_copy", 15'(15'h0400 + i),
                     8'(i ^ 8'h5A));

        // FILL across the top of the address space
        cpu_write(15'd2, 8'h77);
        cpu_write(15'h0500, 8'h12);
        start_cmd(1'b0, 1'b0, '0, 15'h7FFE,
                  16'd4, 8'hC3);
        wait_idle(1'b1, cyc);
        chk("wrap_cycles", 32'(cyc), 4);
        cpu_read("wrap_m1", 15'h7FFE, 8'hC3);
        cpu_read("wrap_max", 15'h7FFF, 8'hC3);
        cpu_read("wrap_0", 15'h0000, 8'hC3);
        cpu_read("wrap_1", 15'h0001, 8'hC3);
        cpu_read("wrap_2", 15'h0002, 8'h77);
        cpu_read("busy_start_ign", 15'h0500, 8'h12);

        // Zero-length command
        cpu_write(15'h0600, 8'h44);
        start_cmd(1'b0, 1'b0, '0, 15'h0600,
                  16'd0, 8'h99);
        chk("len0_busy", 32'(busy), 0);
        chk("len0_done", 32'(done), 1);
        tick();
        chk("len0_done_once", 32'(done), 0);
        cpu_read("len0_nowrite", 15'h0600, 8'h44);

        // Read-first collision on video port
        cpu_write(15'h0200, 8'h11);
        vid_addr = 15'h0200;
        cpu_addr = 15'h0200;
        cpu_din  = 8'h22;
        cpu_we   = 1'b1;
        tick();
        cpu_we   = 1'b0;
        chk("coll_old", 32'(vid_dout), 32'h11);
        tick();
        chk("coll_new", 32'(vid_dout), 32'h22);

        // Abort COPY after 5 of 10 words
        for (int i = 0; i < 10; i++) begin
            cpu_write(15'(15'h0700 + i), 8'(8'h80 + i));
            cpu_write(15'(15'h0800 + i), 8'h00);
        end
        start_cmd(1'b1, 1'b0, 15'h0700, 15'h0800,
                  16'd10, 8'h00);
        for (int i = 0; i < 10; i++) tick();
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        tick();
        chk("abort_no_done", 32'(done), 0);
        for (int i = 0; i < 10; i++)
            cpu_read("abort_data", 15'(15'h0800 + i),
                     (i < 5) ? 8'(8'h80 + i) : 8'h00);

        // Asynchronous reset in the middle of a FILL
        start_cmd(1'b0, 1'b0, '0, 15'h0900,
                  16'd16, 8'h5F);
        tick();
        tick();
        chk("pre_rst_busy", 32'(busy), 1);
        chk("pre_rst_vid", 32'(vid_dout), 32'h22);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_vld", 32'(cpu_dout_vld), 0);
        chk("arst_cpu_dout", 32'(cpu_dout), 0);
        chk("arst_vid_dout", 32'(vid_dout), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed",
                 tests, fails);
        $finish;
    end

endmodule
